// File: rtl/mem_loader.sv
// Byte-stream memory loader: parses command/address/payload records into
// instruction or data word-pair outputs and holds the core in reset while loading.
module mem_loader #(
  parameter int         ADDR_W   = 9,
  parameter logic [7:0] CMD_INST = 8'h01,
  parameter logic [7:0] CMD_DATA = 8'h02,
  parameter logic [7:0] CMD_RUN  = 8'h03,
  parameter logic [7:0] CMD_HALT = 8'h04
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  output logic              enable_load_ex_mem,
  output logic              core_reset,
  output logic [ADDR_W-1:0] InstExMemAddress,
  output logic [31:0]       InstExMemData1,
  output logic [31:0]       InstExMemData2,
  output logic [ADDR_W-1:0] DataExMemAddress,
  output logic [31:0]       DataExMemData1,
  output logic [31:0]       DataExMemData2,
  output logic [15:0]       rec_count,
  output logic              err
);

  typedef enum logic [2:0] {IDLE, ADDR_HI, ADDR_LO, PAYLOAD, COMMIT, RUN} state_t;

  state_t      state, state_n;
  logic        accept;
  logic        err_set;
  logic        tgt_data;
  logic        addr_hi;
  logic [7:0]  addr_lo;
  logic [2:0]  cnt;
  logic [63:0] pay;

  assign in_ready = (state != COMMIT);
  assign accept   = in_valid & in_ready;

  always_comb begin
    state_n = state;
    err_set = 1'b0;
    case (state)
      IDLE: if (accept) begin
        if (in_data == CMD_INST || in_data == CMD_DATA) state_n = ADDR_HI;
        else if (in_data == CMD_RUN)                    state_n = RUN;
        else if (in_data != CMD_HALT)                   err_set = 1'b1;
      end
      ADDR_HI: if (accept) begin
        if (in_data[7:1] != 7'd0) begin
          state_n = IDLE;
          err_set = 1'b1;
        end else begin
          state_n = ADDR_LO;
        end
      end
      ADDR_LO: if (accept) state_n = PAYLOAD;
      PAYLOAD: if (accept && cnt == 3'd7) state_n = COMMIT;
      COMMIT:  state_n = IDLE;
      RUN:     if (accept && in_data == CMD_HALT) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state              <= IDLE;
      enable_load_ex_mem <= 1'b1;
      core_reset         <= 1'b1;
      err                <= 1'b0;
      tgt_data           <= 1'b0;
      addr_hi            <= 1'b0;
      addr_lo            <= '0;
      cnt                <= '0;
      pay                <= '0;
      rec_count          <= '0;
      InstExMemAddress   <= '0;
      InstExMemData1     <= '0;
      InstExMemData2     <= '0;
      DataExMemAddress   <= '0;
      DataExMemData1     <= '0;
      DataExMemData2     <= '0;
    end else begin
      state <= state_n;
      // Registered from next state so both flip on the edge entering/leaving RUN.
      enable_load_ex_mem <= (state_n != RUN);
      core_reset         <= (state_n != RUN);
      if (err_set) err <= 1'b1;

      if (accept) begin
        case (state)
          IDLE:    if (in_data == CMD_INST || in_data == CMD_DATA) tgt_data <= (in_data == CMD_DATA);
          ADDR_HI: addr_hi <= in_data[0];
          ADDR_LO: begin
            addr_lo <= in_data;
            cnt     <= '0;
          end
          PAYLOAD: begin
            pay[{cnt, 3'b000} +: 8] <= in_data;
            cnt                     <= cnt + 3'd1;
          end
          default: ;
        endcase
      end

      if (state == COMMIT) begin
        if (tgt_data) begin
          DataExMemAddress <= ADDR_W'({addr_hi, addr_lo});
          DataExMemData1   <= pay[31:0];
          DataExMemData2   <= pay[63:32];
        end else begin
          InstExMemAddress <= ADDR_W'({addr_hi, addr_lo});
          InstExMemData1   <= pay[31:0];
          InstExMemData2   <= pay[63:32];
        end
        if (rec_count != 16'hFFFF) rec_count <= rec_count + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_mem_loader.sv
// Self-checking bench for mem_loader: directed scenarios plus randomized records
// compared against a record-level reference model.
module tb_mem_loader;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic [7:0]  in_data;
  logic        in_ready;
  logic        enable_load_ex_mem;
  logic        core_reset;
  logic [8:0]  InstExMemAddress, DataExMemAddress;
  logic [31:0] InstExMemData1, InstExMemData2, DataExMemData1, DataExMemData2;
  logic [15:0] rec_count;
  logic        err;

  int total = 0;
  int bad   = 0;

  // Reference model state: what each output should read after the last commit.
  logic [8:0]  m_iaddr, m_daddr;
  logic [31:0] m_i1, m_i2, m_d1, m_d2;
  int          m_cnt;
  logic        m_err;

  mem_loader #(.ADDR_W(9)) dut (
    .clk                (clk),
    .reset              (rst_n),
    .in_valid           (in_valid),
    .in_data            (in_data),
    .in_ready           (in_ready),
    .enable_load_ex_mem (enable_load_ex_mem),
    .core_reset         (core_reset),
    .InstExMemAddress   (InstExMemAddress),
    .InstExMemData1     (InstExMemData1),
    .InstExMemData2     (InstExMemData2),
    .DataExMemAddress   (DataExMemAddress),
    .DataExMemData1     (DataExMemData1),
    .DataExMemData2     (DataExMemData2),
    .rec_count          (rec_count),
    .err                (err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_iaddr = '0; m_daddr = '0;
    m_i1 = '0; m_i2 = '0; m_d1 = '0; m_d2 = '0;
    m_cnt = 0; m_err = 1'b0;
  endtask

  task automatic check_all(input string tag);
    check({tag, ".iaddr"}, 64'(InstExMemAddress), 64'(m_iaddr));
    check({tag, ".i1"},    64'(InstExMemData1),   64'(m_i1));
    check({tag, ".i2"},    64'(InstExMemData2),   64'(m_i2));
    check({tag, ".daddr"}, 64'(DataExMemAddress), 64'(m_daddr));
    check({tag, ".d1"},    64'(DataExMemData1),   64'(m_d1));
    check({tag, ".d2"},    64'(DataExMemData2),   64'(m_d2));
    check({tag, ".cnt"},   64'(rec_count),        64'(m_cnt));
    check({tag, ".err"},   64'(err),              64'(m_err));
  endtask

  // Present one byte and hold it until accepted; returns just after the accepting edge.
  task automatic send_byte(input logic [7:0] b, input bit gaps);
    int n;
    if (gaps) repeat ($urandom_range(0, 3)) @(negedge clk);
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = b;
    n = 0;
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) check("accept_timeout", 64'(n), 64'd0);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_data  = $urandom_range(0, 255);
  endtask

  // Send a full record, check the single COMMIT cycle, then the committed outputs.
  task automatic send_record(input string tag, input bit is_data, input logic [8:0] addr,
                             input logic [63:0] payload, input bit gaps);
    logic [7:0] hi;
    hi = {7'd0, addr[8]};
    send_byte(is_data ? 8'h02 : 8'h01, gaps);
    send_byte(hi, gaps);
    send_byte(addr[7:0], gaps);
    for (int i = 0; i < 8; i++) send_byte(payload[i*8 +: 8], gaps);
    check({tag, ".commit_rdy"}, 64'(in_ready), 64'd0);
    @(posedge clk);
    #1;
    check({tag, ".after_rdy"}, 64'(in_ready), 64'd1);
    if (is_data) begin
      m_daddr = addr; m_d1 = payload[31:0]; m_d2 = payload[63:32];
    end else begin
      m_iaddr = addr; m_i1 = payload[31:0]; m_i2 = payload[63:32];
    end
    if (m_cnt < 65535) m_cnt++;
    check_all(tag);
  endtask

  initial begin
    logic [63:0] p;
    logic [8:0]  a;
    logic [7:0]  b;
    in_valid = 1'b0;
    in_data  = '0;
    rst_n    = 1'b1;
    model_reset();

    // Reset values
    #2 rst_n = 1'b0;
    #1;
    check_all("reset");
    check("reset.rdy", 64'(in_ready), 64'd1);
    check("reset.en",  64'(enable_load_ex_mem), 64'd1);
    check("reset.cr",  64'(core_reset), 64'd1);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Instruction record, gap-free
    send_record("inst1", 1'b0, 9'h005, 64'hDEADBEEF_12345678, 1'b0);

    // Data record at top address; instruction outputs must hold
    send_record("data1", 1'b1, 9'h1FF, 64'h07060504_03020100, 1'b0);

    // RUN / HALT
    send_byte(8'h03, 1'b0);
    check("run.en", 64'(enable_load_ex_mem), 64'd0);
    check("run.cr", 64'(core_reset), 64'd0);
    send_byte(8'h01, 1'b0);
    send_byte(8'h7F, 1'b0);
    check("run.err", 64'(err), 64'd0);
    check("run.en2", 64'(enable_load_ex_mem), 64'd0);
    send_byte(8'h04, 1'b0);
    check("halt.en", 64'(enable_load_ex_mem), 64'd1);
    check("halt.cr", 64'(core_reset), 64'd1);
    check_all("halt");

    // Illegal command and illegal ADDR_HI
    send_byte(8'h7F, 1'b0);
    m_err = 1'b1;
    check_all("badcmd");
    send_byte(8'h01, 1'b0);
    send_byte(8'h02, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    check_all("badhi");
    send_record("after_err", 1'b0, 9'h104, 64'h01020304_03020104, 1'b0);

    // Reset mid-record after 5 payload bytes
    send_byte(8'h02, 1'b0);
    send_byte(8'h00, 1'b0);
    send_byte(8'h33, 1'b0);
    for (int i = 0; i < 5; i++) send_byte(8'hA0 + 8'(i), 1'b0);
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    check_all("midreset");
    check("midreset.rdy", 64'(in_ready), 64'd1);
    check("midreset.en",  64'(enable_load_ex_mem), 64'd1);
    check("midreset.cr",  64'(core_reset), 64'd1);
    @(negedge clk);
    rst_n    = 1'b1;
    // First byte presented so it is taken on the very first edge after release
    in_valid = 1'b1;
    in_data  = 8'h01;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    send_byte(8'h00, 1'b0);
    send_byte(8'h42, 1'b0);
    p = 64'h89ABCDEF_01234567;
    for (int i = 0; i < 8; i++) send_byte(p[i*8 +: 8], 1'b0);
    @(posedge clk);
    #1;
    m_iaddr = 9'h042; m_i1 = p[31:0]; m_i2 = p[63:32]; m_cnt = 1;
    check_all("first_edge");

    // Randomized mix of records (with and without gaps), RUN sessions and bad commands
    for (int it = 0; it < 40; it++) begin
      case ($urandom_range(0, 9))
        0: begin
          b = 8'(32'h05 + $urandom_range(0, 250));
          send_byte(b, 1'b1);
          m_err = 1'b1;
          check("rnd.badcmd", 64'(err), 64'd1);
        end
        1: begin
          send_byte(8'h03, 1'b1);
          repeat ($urandom_range(0, 3)) begin
            b = 8'($urandom_range(0, 255));
            if (b == 8'h04) b = 8'h01;
            send_byte(b, 1'b1);
          end
          check("rnd.run_en", 64'(enable_load_ex_mem), 64'd0);
          send_byte(8'h04, 1'b1);
          check_all("rnd.halt");
        end
        default: begin
          a = 9'($urandom_range(0, 511));
          p = {$urandom(), $urandom()};
          if (it % 4 == 2) p[15:0] = 16'h0403;
          send_record("rnd.rec", 1'($urandom_range(0, 1)), a, p, 1'(it % 2));
        end
      endcase
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    bad++;
    $display("test done: total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog expired");
  end

endmodule
